// File: rtl/id_exe_if.sv
// ---------------------------------------------------------------------------
// id_exe_if : ID/EXE pipeline register bundle
//
// Groups the ID-side inputs, the EXE-side registered outputs, the hazard
// controls (freeze / flush) and the debug event counters of id_exe_reg.
//   master : driven by the ID stage / hazard unit, observes the EXE side
//   slave  : the pipeline register itself
//
// Optional feature macro: ID_EXE_FWD_EN adds src1/src2 (Rn/Rm addresses)
// for the forwarding unit.
// ---------------------------------------------------------------------------
interface id_exe_if #(
  parameter int CNT_W = 16
);
  // hazard controls
  logic             freeze;
  logic             flush;
  // ID-side fields
  logic             wb_en_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic             b_in;
  logic             s_in;
  logic [3:0]       exe_cmd_in;
  logic [31:0]      pc_in;
  logic [31:0]      val_rn_in;
  logic [31:0]      val_rm_in;
  logic             imm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      signed_imm_24_in;
  logic [3:0]       dest_in;
  logic [3:0]       status_in;
`ifdef ID_EXE_FWD_EN
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
`endif
  // EXE-side registered fields
  logic             wb_en_out;
  logic             mem_r_en_out;
  logic             mem_w_en_out;
  logic             b_out;
  logic             s_out;
  logic [3:0]       exe_cmd_out;
  logic [31:0]      pc_out;
  logic [31:0]      val_rn_out;
  logic [31:0]      val_rm_out;
  logic             imm_out;
  logic [11:0]      shift_operand_out;
  logic [23:0]      signed_imm_24_out;
  logic [3:0]       dest_out;
  logic [3:0]       status_out;
`ifdef ID_EXE_FWD_EN
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;
`endif
  logic             valid_out;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output freeze, flush,
    output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
    output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
    output signed_imm_24_in, dest_in, status_in,
`ifdef ID_EXE_FWD_EN
    output src1_in, src2_in,
    input  src1_out, src2_out,
`endif
    input  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
    input  pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
    input  signed_imm_24_out, dest_out, status_out,
    input  valid_out, stall_cnt, flush_cnt
  );

  modport slave (
    input  freeze, flush,
    input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
    input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
    input  signed_imm_24_in, dest_in, status_in,
`ifdef ID_EXE_FWD_EN
    input  src1_in, src2_in,
    output src1_out, src2_out,
`endif
    output wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
    output pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
    output signed_imm_24_out, dest_out, status_out,
    output valid_out, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// ---------------------------------------------------------------------------
// id_exe_reg : ID/EXE pipeline register of the five-stage ARM core
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-low; clears every output and counter
//   bus  - id_exe_if.slave: ID-side *_in fields, freeze/flush controls,
//          registered *_out fields, valid_out, stall_cnt, flush_cnt
//
// Per edge, priority flush > freeze > load:
//   flush  : all fields to 0 (a NOP bubble), valid_out=0, flush_cnt++
//   freeze : everything holds, stall_cnt++
//   load   : fields take the ID-side values, valid_out=1
// Counters saturate at all-ones. All outputs come straight from flops.
//
// Optional feature macro: ID_EXE_FWD_EN adds the src1/src2 fields.
// ---------------------------------------------------------------------------
module id_exe_reg #(
  parameter int CNT_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  id_exe_if.slave bus
);

`ifdef ID_EXE_FWD_EN
  localparam int FWD_W = 8;
`else
  localparam int FWD_W = 0;
`endif
  // 5 control bits + cmd + pc + rn + rm + imm + shifter + offset + dest + status
  localparam int BASE_W   = 5 + 4 + 32 + 32 + 32 + 1 + 12 + 24 + 4 + 4;
  localparam int BUNDLE_W = BASE_W + FWD_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BUNDLE_W-1:0] w_bundle_in;
  logic [BUNDLE_W-1:0] r_bundle;
  logic                r_valid;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // Every field is packed so that flush, freeze and load act on one vector;
  // an all-zero bundle is exactly the NOP bubble (exe_cmd 0000, no writes).
  assign w_bundle_in = {
`ifdef ID_EXE_FWD_EN
    bus.src1_in, bus.src2_in,
`endif
    bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.b_in, bus.s_in,
    bus.exe_cmd_in, bus.pc_in, bus.val_rn_in, bus.val_rm_in, bus.imm_in,
    bus.shift_operand_in, bus.signed_imm_24_in, bus.dest_in, bus.status_in
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bundle    <= '0;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.flush) begin
      // flush wins over freeze: only the flush counter moves
      r_bundle <= '0;
      r_valid  <= 1'b0;
      if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + 1'b1;
    end else if (bus.freeze) begin
      if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_bundle <= w_bundle_in;
      r_valid  <= 1'b1;
    end
  end

  assign {
`ifdef ID_EXE_FWD_EN
    bus.src1_out, bus.src2_out,
`endif
    bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.b_out, bus.s_out,
    bus.exe_cmd_out, bus.pc_out, bus.val_rn_out, bus.val_rm_out, bus.imm_out,
    bus.shift_operand_out, bus.signed_imm_24_out, bus.dest_out, bus.status_out
  } = r_bundle;

  assign bus.valid_out = r_valid;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_reg : self-checking bench for id_exe_reg (CNT_W = 2 so that
// counter saturation is reachable; reset between scenarios clears counters).
// ---------------------------------------------------------------------------
module tb_id_exe_reg;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk;
  logic rst;

  id_exe_if #(.CNT_W(CNT_W)) bus ();

  id_exe_reg #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, st;
`ifdef ID_EXE_FWD_EN
    logic [3:0]  s1, s2;
`endif
    logic        vld;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t m;          // reference state after the latest edge
  exp_t sb[$];      // scoreboard of expected post-edge outputs
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare(input exp_t e, input string tag);
    check({tag, "_ctrl"},
          {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.b_out, bus.s_out,
           bus.exe_cmd_out, bus.imm_out},
          {e.wb, e.mr, e.mw, e.b, e.s, e.cmd, e.imm});
    check({tag, "_pc"}, bus.pc_out, e.pc);
    check({tag, "_rn_rm"}, {bus.val_rn_out, bus.val_rm_out}, {e.rn, e.rm});
    check({tag, "_sh_si"}, {bus.shift_operand_out, bus.signed_imm_24_out}, {e.sh, e.si});
    check({tag, "_dest_st"}, {bus.dest_out, bus.status_out}, {e.dest, e.st});
`ifdef ID_EXE_FWD_EN
    check({tag, "_src"}, {bus.src1_out, bus.src2_out}, {e.s1, e.s2});
`endif
    check({tag, "_valid"}, bus.valid_out, e.vld);
    check({tag, "_cnt"}, {bus.stall_cnt, bus.flush_cnt}, {e.sc, e.fc});
  endtask

  task automatic drive_rand();
    bus.wb_en_in         = 1'($urandom);
    bus.mem_r_en_in      = 1'($urandom);
    bus.mem_w_en_in      = 1'($urandom);
    bus.b_in             = 1'($urandom);
    bus.s_in             = 1'($urandom);
    bus.exe_cmd_in       = 4'($urandom);
    bus.pc_in            = $urandom;
    bus.val_rn_in        = $urandom;
    bus.val_rm_in        = $urandom;
    bus.imm_in           = 1'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in          = 4'($urandom);
    bus.status_in        = 4'($urandom);
`ifdef ID_EXE_FWD_EN
    bus.src1_in          = 4'($urandom);
    bus.src2_in          = 4'($urandom);
`endif
  endtask

  task automatic drive_ones();
    bus.wb_en_in = 1'b1; bus.mem_r_en_in = 1'b1; bus.mem_w_en_in = 1'b1;
    bus.b_in = 1'b1; bus.s_in = 1'b1; bus.exe_cmd_in = 4'hF;
    bus.pc_in = '1; bus.val_rn_in = '1; bus.val_rm_in = '1; bus.imm_in = 1'b1;
    bus.shift_operand_in = '1; bus.signed_imm_24_in = '1;
    bus.dest_in = 4'hF; bus.status_in = 4'hF;
`ifdef ID_EXE_FWD_EN
    bus.src1_in = 4'hF; bus.src2_in = 4'hF;
`endif
    bus.freeze = 1'b1; bus.flush = 1'b1;
  endtask

  // Reference behaviour of one rising edge
  task automatic model_edge(input logic fz, input logic fl);
    if (fl) begin
      m.wb = 0; m.mr = 0; m.mw = 0; m.b = 0; m.s = 0; m.cmd = '0;
      m.pc = '0; m.rn = '0; m.rm = '0; m.imm = 0; m.sh = '0; m.si = '0;
      m.dest = '0; m.st = '0;
`ifdef ID_EXE_FWD_EN
      m.s1 = '0; m.s2 = '0;
`endif
      m.vld = 1'b0;
      if (m.fc != CMAX) m.fc = m.fc + 1'b1;
    end else if (fz) begin
      if (m.sc != CMAX) m.sc = m.sc + 1'b1;
    end else begin
      m.wb = bus.wb_en_in; m.mr = bus.mem_r_en_in; m.mw = bus.mem_w_en_in;
      m.b = bus.b_in; m.s = bus.s_in; m.cmd = bus.exe_cmd_in;
      m.pc = bus.pc_in; m.rn = bus.val_rn_in; m.rm = bus.val_rm_in;
      m.imm = bus.imm_in; m.sh = bus.shift_operand_in; m.si = bus.signed_imm_24_in;
      m.dest = bus.dest_in; m.st = bus.status_in;
`ifdef ID_EXE_FWD_EN
      m.s1 = bus.src1_in; m.s2 = bus.src2_in;
`endif
      m.vld = 1'b1;
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic step(input logic fz, input logic fl);
    exp_t e;
    bus.freeze = fz;
    bus.flush  = fl;
    model_edge(fz, fl);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      compare(e, "step");
    end
    @(negedge clk);
  endtask

  // Called mid-cycle: asserts reset, checks the immediate clear, releases
  // reset at the next falling edge so no edge is seen with rst low released.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    m = '0;
    sb.delete();
    compare(m, tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive_ones();
    m = '0;

    // Reset with every input nonzero, before any clock edge
    do_reset("rst_init");
    drive_rand();
    bus.exe_cmd_in = 4'b0010;
    bus.dest_in    = 4'd5;
    step(1'b0, 1'b0);
    check("first_cmd", bus.exe_cmd_out, 64'h2);
    check("first_dest", bus.dest_out, 64'd5);
    check("first_valid", bus.valid_out, 64'd1);

    // Stream of three loads
    for (int i = 1; i <= 3; i++) begin
      drive_rand();
      bus.pc_in = 32'(4 * i);
      step(1'b0, 1'b0);
      check("stream_pc", bus.pc_out, 64'(4 * i));
    end

    // Freeze for three edges
    do_reset("rst_frz");
    drive_rand();
    bus.pc_in = 32'd8;
    step(1'b0, 1'b0);
    drive_rand();
    bus.pc_in = 32'd12;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("frz_pc", bus.pc_out, 64'd8);
    end
    check("frz_stall", bus.stall_cnt, 64'd3);
    step(1'b0, 1'b0);
    check("unfrz_pc", bus.pc_out, 64'd12);

    // Flush beats freeze
    do_reset("rst_fl");
    drive_rand();
    bus.wb_en_in    = 1'b1;
    bus.mem_w_en_in = 1'b1;
    step(1'b0, 1'b0);
    check("pre_fl_ctrl", {bus.wb_en_out, bus.mem_w_en_out}, 64'h3);
    drive_rand();
    step(1'b1, 1'b1);
    check("fl_ctrl", {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out,
                      bus.b_out, bus.s_out, bus.exe_cmd_out}, 64'd0);
    check("fl_valid", bus.valid_out, 64'd0);
    check("fl_fcnt", bus.flush_cnt, 64'd1);
    check("fl_scnt", bus.stall_cnt, 64'd0);

    // Stall counter saturation
    do_reset("rst_sat");
    for (int i = 1; i <= 5; i++) begin
      drive_rand();
      step(1'b1, 1'b0);
      check("sat_stall", bus.stall_cnt, 64'(i > 3 ? 3 : i));
    end

    // Async reset in the middle of a freeze
    do_reset("rst_mid0");
    drive_rand();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_stall", bus.stall_cnt, 64'd2);
    do_reset("rst_mid");
    drive_rand();
    bus.pc_in = 32'd64;
    step(1'b0, 1'b0);
    check("post_rst_pc", bus.pc_out, 64'd64);

    // Random mix of loads, freezes and flushes
    for (int i = 0; i < 60; i++) begin
      drive_rand();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

ID/EXE pipeline register of the five-stage ARM core. Captures the decoded control bundle from the control unit, plus operand values, immediates, destination and status flags from the ID stage, on each rising clock edge, and presents them to the EXE stage. Supports hazard freeze (hold) and branch flush (bubble insertion). Keeps saturating stall and flush event counters for debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- freeze  in  1  hazard stall from the hazard unit: hold all registers
- flush  in  1  branch taken in EXE: insert a bubble
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits from the control unit
- exe_cmd_in  in  4  ALU command from the control unit
- pc_in  in  32  PC+4 of the ID instruction
- val_rn_in, val_rm_in  in  32 each  register-file read data
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  Rd
- status_in  in  4  NZCV from the status register
- src1_in, src2_in  in  4 each  Rn/Rm addresses (only with ID_EXE_FWD_EN)
- *_out  out  same widths  registered copies of every *_in above
- valid_out  out  1  EXE slot holds a real instruction (not a bubble or reset)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Reset: every output, including valid_out and both counters, goes to 0 immediately and asynchronously. Reset has priority over every other input.
- Each rising edge selects one action, evaluated in priority order flush > freeze > load:
  - flush=1: all *_out go to 0 and valid_out goes to 0. If flush_cnt < 2^CNT_W−1, flush_cnt increments by 1.
  - flush=0, freeze=1: all *_out and valid_out hold. If stall_cnt < 2^CNT_W−1, stall_cnt increments by 1.
  - Otherwise (load): every *_out takes its *_in, and valid_out goes to 1.
- A bubble drives wb_en, mem_r_en, mem_w_en, b and s to 0, and exe_cmd to 0000 (NOP). A bubble therefore has no architectural effect.
- When flush and freeze are asserted together, only flush_cnt counts. stall_cnt does not count.
- Counters saturate at all-ones and never wrap. Only rst clears them.
- The block has no combinational path from any input to any output.

## Timing
- Load latency is 1 cycle: an input sampled at edge N is visible on the outputs after edge N.
- freeze held for K cycles holds the outputs for K edges. The first edge after freeze deasserts loads the current inputs.
- A one-cycle flush pulse produces exactly one bubble cycle on the outputs.
- Reset asserted mid-stream clears the outputs within the same cycle, without waiting for a clock edge. The first edge after rst returns to 1 performs a normal load (or a flush or freeze, if asserted).

## Configuration
- Macro ID_EXE_FWD_EN.
- Defined: the src1_in/src2_in ports and the src1_out/src2_out registers exist. They follow the same reset, flush (to 0), freeze and load rules as the other fields, and feed the forwarding unit.
- Undefined: these four ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with every input nonzero → all outputs 0, valid_out=0, stall_cnt=flush_cnt=0 with no clock edge. Release rst and apply one edge with exe_cmd_in=0010 and dest_in=5 → exe_cmd_out=0010, dest_out=5, valid_out=1.
- Stream: load three instructions on consecutive edges with pc_in=4, 8, 12 → pc_out=4, 8, 12 on the following three cycles.
- Freeze: load pc_in=8, then hold freeze=1 for 3 edges while pc_in=12 → pc_out stays 8 for 3 cycles and stall_cnt=3. Deassert freeze → next edge gives pc_out=12.
- Flush priority: loaded instruction with wb_en=1 and mem_w_en=1; assert flush=1 and freeze=1 on the same edge → all control outputs 0, valid_out=0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=2, hold freeze=1 for 5 edges → stall_cnt sequence 1, 2, 3, 3, 3.
- Async reset mid-freeze: with freeze=1 and stall_cnt=2, pulse rst=0 between edges → all outputs and counters clear immediately. With ID_EXE_FWD_EN defined, src1_out and src2_out also clear.
